// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on tck with combinational state decodes
// and registered one-cycle update strobes for the IR and DR paths.
module tap_controller (
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic reset,
    output logic tdo_en,
    output logic shiftIR,
    output logic shiftDR,
    output logic captureIR,
    output logic captureDR,
    output logic clockIR,
    output logic clockDR,
    output logic updateIR,
    output logic updateDR,
    output logic updateDRstate,
    output logic select
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   update_ir_q;
    logic   update_dr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Strobes follow the Update-xR state by one cycle; a new visit always
    // passes through at least one other state, so pulses cannot merge.
    always_ff @(posedge tck) begin
        if (trst) begin
            state_q     <= TLR;
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            update_ir_q <= (state_q == UPD_IR);
            update_dr_q <= (state_q == UPD_DR);
        end
    end

    assign reset         = (state_q == TLR);
    assign shiftIR       = (state_q == SHIFT_IR);
    assign shiftDR       = (state_q == SHIFT_DR);
    assign captureIR     = (state_q == CAP_IR);
    assign captureDR     = (state_q == CAP_DR);
    assign clockIR       = captureIR | shiftIR;
    assign clockDR       = captureDR | shiftDR;
    assign tdo_en        = shiftIR | shiftDR;
    assign updateDRstate = (state_q == UPD_DR);
    assign updateIR      = update_ir_q;
    assign updateDR      = update_dr_q;

    // The IR-path states occupy a contiguous encoding range.
    assign select        = (state_q >= SEL_IR);

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: directed tms/trst vectors push hand-computed
// output vectors; a monitor pops and compares one vector per tck cycle.
module tb_tap_controller;

    logic tck;
    logic trst;
    logic tms;
    logic reset, tdo_en, shiftIR, shiftDR, captureIR, captureDR;
    logic clockIR, clockDR, updateIR, updateDR, updateDRstate, select;

    tap_controller dut (
        .tck           (tck),
        .trst          (trst),
        .tms           (tms),
        .reset         (reset),
        .tdo_en        (tdo_en),
        .shiftIR       (shiftIR),
        .shiftDR       (shiftDR),
        .captureIR     (captureIR),
        .captureDR     (captureDR),
        .clockIR       (clockIR),
        .clockDR       (clockDR),
        .updateIR      (updateIR),
        .updateDR      (updateDR),
        .updateDRstate (updateDRstate),
        .select        (select)
    );

    // Vector bits: reset select tdo_en shiftIR shiftDR captureIR captureDR
    //              clockIR clockDR updateIR updateDR updateDRstate
    localparam logic [11:0] E_TLR  = 12'h800;
    localparam logic [11:0] E_ZERO = 12'h000;
    localparam logic [11:0] E_IR   = 12'h400;
    localparam logic [11:0] E_CDR  = 12'h028;
    localparam logic [11:0] E_SDR  = 12'h288;
    localparam logic [11:0] E_UDR  = 12'h001;
    localparam logic [11:0] E_CIR  = 12'h450;
    localparam logic [11:0] E_SIR  = 12'h710;
    localparam logic [11:0] S_UIR  = 12'h004;
    localparam logic [11:0] S_UDR  = 12'h002;

    typedef struct {
        logic [11:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit stim_done = 0;

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic step(input logic t, input logic m, input logic [11:0] e, input string nm);
        sb_item_t it;
        @(negedge tck);
        trst = t;
        tms  = m;
        it.exp  = e;
        it.name = nm;
        exp_q.push_back(it);
    endtask

    initial begin : monitor
        sb_item_t it;
        logic [11:0] got;
        forever begin
            @(posedge tck);
            #1;
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                got = {reset, select, tdo_en, shiftIR, shiftDR, captureIR, captureDR,
                       clockIR, clockDR, updateIR, updateDR, updateDRstate};
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %03h expected %03h", it.name, got, it.exp);
                end else begin
                    $display("check %0d %s: outputs %03h ok", checks, it.name, got);
                end
            end
        end
    end

    initial begin : stimulus
        trst = 1'b1;
        tms  = 1'b0;
        step(1, 1, E_TLR,  "reset_a");
        step(1, 0, E_TLR,  "reset_b");
        step(0, 1, E_TLR,  "tlr_hold");
        step(0, 0, E_ZERO, "rti");
        // DR scan with pause and re-entry to shift
        step(0, 1, E_ZERO, "sel_dr");
        step(0, 0, E_CDR,  "cap_dr");
        step(0, 0, E_SDR,  "shift_dr");
        step(0, 0, E_SDR,  "shift_dr_hold");
        step(0, 1, E_ZERO, "exit1_dr");
        step(0, 0, E_ZERO, "pause_dr");
        step(0, 0, E_ZERO, "pause_dr_hold");
        step(0, 1, E_ZERO, "exit2_dr");
        step(0, 0, E_SDR,  "shift_dr_again");
        step(0, 1, E_ZERO, "exit1_dr_b");
        step(0, 1, E_UDR,  "upd_dr");
        step(0, 0, S_UDR,  "rti_updDR_strobe");
        step(0, 0, E_ZERO, "rti_no_strobe");
        // back-to-back Update-DR visits give one pulse each
        step(0, 1, E_ZERO, "sel_dr_b");
        step(0, 0, E_CDR,  "cap_dr_b");
        step(0, 1, E_ZERO, "exit1_dr_c");
        step(0, 1, E_UDR,  "upd_dr_b");
        step(0, 1, S_UDR,  "sel_dr_strobe");
        step(0, 0, E_CDR,  "cap_dr_c");
        step(0, 1, E_ZERO, "exit1_dr_d");
        step(0, 1, E_UDR,  "upd_dr_c");
        step(0, 1, S_UDR,  "sel_dr_strobe_b");
        step(0, 0, E_CDR,  "cap_dr_d");
        step(0, 0, E_SDR,  "shift_dr_b");
        // trst mid-shift
        step(1, 0, E_TLR,  "trst_mid_shift");
        step(0, 0, E_ZERO, "rti_after_trst");
        // IR scan
        step(0, 1, E_ZERO, "sel_dr_c");
        step(0, 1, E_IR,   "sel_ir");
        step(0, 0, E_CIR,  "cap_ir");
        step(0, 0, E_SIR,  "shift_ir");
        step(0, 0, E_SIR,  "shift_ir_hold");
        step(0, 1, E_IR,   "exit1_ir");
        step(0, 0, E_IR,   "pause_ir");
        step(0, 1, E_IR,   "exit2_ir");
        step(0, 1, E_IR,   "upd_ir");
        step(0, 0, S_UIR,  "rti_updIR_strobe");
        step(0, 0, E_ZERO, "rti_b");
        // five tms=1 from RTI
        step(0, 1, E_ZERO, "tms1_a");
        step(0, 1, E_IR,   "tms1_b");
        step(0, 1, E_TLR,  "tms1_c");
        step(0, 1, E_TLR,  "tms1_d");
        step(0, 1, E_TLR,  "tms1_e");
        // five tms=1 from Shift-IR
        step(0, 0, E_ZERO, "rti_c");
        step(0, 1, E_ZERO, "sel_dr_d");
        step(0, 1, E_IR,   "sel_ir_b");
        step(0, 0, E_CIR,  "cap_ir_b");
        step(0, 0, E_SIR,  "shift_ir_b");
        step(0, 1, E_IR,   "sir_tms1_a");
        step(0, 1, E_IR,   "sir_tms1_b");
        step(0, 1, S_UIR,  "sir_tms1_c");
        step(0, 1, E_IR,   "sir_tms1_d");
        step(0, 1, E_TLR,  "sir_tms1_e");
        // trst in Update-DR suppresses the pending strobe
        step(0, 0, E_ZERO, "rti_d");
        step(0, 1, E_ZERO, "sel_dr_e");
        step(0, 0, E_CDR,  "cap_dr_e");
        step(0, 1, E_ZERO, "exit1_dr_e");
        step(0, 1, E_UDR,  "upd_dr_d");
        step(1, 0, E_TLR,  "trst_in_upd_dr");
        step(0, 0, E_ZERO, "rti_e");
        stim_done = 1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge tck);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: timeout reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have one clock, tck, input, 1 bit; all state updates occur on its rising edge.
REQ-002 SHALL have trst, input, 1 bit: the reset; it is synchronous and active-high.
REQ-003 SHALL have tms, input, 1 bit: test mode select, sampled on rising tck.
REQ-004 SHALL have reset, output, 1 bit: high while in Test-Logic-Reset (TLR).
REQ-005 SHALL have tdo_en, output, 1 bit: high in Shift-DR or Shift-IR.
REQ-006 SHALL have shiftIR/shiftDR, outputs, 1 bit each: high in Shift-IR / Shift-DR respectively.
REQ-007 SHALL have captureIR/captureDR, outputs, 1 bit each: high in Capture-IR / Capture-DR.
REQ-008 SHALL have clockIR/clockDR, outputs, 1 bit each: register enable, high in Capture-xR or Shift-xR of the respective path.
REQ-009 SHALL have updateIR/updateDR, outputs, 1 bit each: registered one-cycle strobes.
REQ-010 SHALL have updateDRstate, output, 1 bit: high while the state is Update-DR.
REQ-011 SHALL have select, output, 1 bit: 1 = IR path (Select-IR through Update-IR), 0 = otherwise.

Function
REQ-012 SHALL implement the 16-state IEEE 1149.1 TAP FSM; encoding is implementation-free.
REQ-013 Transitions (tms=0 / tms=1): TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; SelIR->CapIR/TLR.
REQ-014 xR path (x=DR or IR): Cap->Shift/Exit1; Shift->Shift/Exit1; Exit1->Pause/Update; Pause->Pause/Exit2; Exit2->Shift/Update; Update->RTI/SelDR.
REQ-015 From any state, five consecutive tms=1 samples SHALL reach TLR.
REQ-016 All outputs except updateIR/updateDR SHALL be combinational decodes of the current state (no extra latency).
REQ-017 updateDR SHALL be high for exactly one cycle, the cycle after the state is Update-DR; updateIR likewise for Update-IR.
REQ-018 Re-entering Update-xR on consecutive visits SHALL produce one strobe per visit; strobes never stretch.
REQ-019 In Pause-xR and Exit-xR states, shift*, capture*, clock* and tdo_en SHALL all be low.
REQ-020 No gated or derived clocks; all logic single-clock-domain on tck.

Reset
REQ-021 trst=1 at a rising tck SHALL force state to TLR regardless of tms or current state, including mid-shift.
REQ-022 After reset: reset=1, select=0; every other output, including the updateIR/updateDR registers, is 0.
REQ-023 Release of trst SHALL let normal tms-driven transitions resume on the next rising tck.
REQ-024 Before the first trst assertion the state is undefined; the bench SHALL reset first.

Verification
REQ-025 Pulse trst during Shift-DR -> next cycle state TLR, reset=1, shiftDR=0, tdo_en=0.
REQ-026 From RTI, tms=1,1,1,1,1 -> TLR with reset=1; from Shift-IR the same sequence also reaches TLR.
REQ-027 From TLR, tms=0,1,0,0 -> Capture-DR (captureDR=1, clockDR=1, select=0) then Shift-DR (shiftDR=1, clockDR=1, tdo_en=1); tms=0 holds Shift-DR.
REQ-028 From Shift-DR, tms=1,0 -> Pause-DR with all shift/clock/tdo_en low, held by tms=0; tms=1,0 -> back to Shift-DR.
REQ-029 From Shift-DR, tms=1,1 -> Update-DR with updateDRstate=1 and updateDR=0; next cycle updateDR=1 for exactly one cycle.
REQ-030 From RTI, tms=1,1,0,0 -> Shift-IR with select=1, shiftIR=1, clockIR=1, tdo_en=1; tms=1,1 -> Update-IR, then one-cycle updateIR pulse while back in RTI/SelDR.
